// File: rtl/cnn_pkg.sv
// Shared definitions for the PE-array front end: element sizes, loader state
// encoding and the flat-bus slot offset helper.
package cnn_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned FILTER_N = 9;
  localparam int unsigned IFMAP_N  = 25;

  typedef enum logic [2:0] {
    LOAD_FLT,
    LOAD_IFM,
    ARR_RST,
    COMPUTE,
    DONE
  } loader_state_e;

  // Lowest bit of element idx inside a flat bus of w-bit elements.
  function automatic int unsigned slot_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/elem_collector.sv
// Collects N sequential elements into a flat register; element k lands at
// bits [k*DATA_W +: DATA_W]. The write pointer wraps to 0 after the last slot.
module elem_collector
  import cnn_pkg::*;
#(
  parameter int unsigned N      = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [N*DATA_W-1:0]   flat_o,
  output logic                  last_o
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N*DATA_W-1:0] flat_q, flat_d;

  assign last_o = (cnt_q == CntW'(N - 1));
  assign flat_o = flat_q;

  always_comb begin
    cnt_d  = cnt_q;
    flat_d = flat_q;
    if (wr_en_i) begin
      flat_d[slot_lsb(32'(cnt_q), DATA_W) +: DATA_W] = data_i;
      cnt_d = last_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flat_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      flat_q <= flat_d;
    end
  end

endmodule

// File: rtl/pe_tile_loader.sv
// Byte-stream loader and sequencer for the 3x3 PE array: filter then ifmap,
// then array reset, compute window and done. PE_TILE_LOADER_FILTER_REUSE_EN adds keep_filter.
module pe_tile_loader
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W         = cnn_pkg::DATA_W,
  parameter int unsigned FILTER_N       = cnn_pkg::FILTER_N,
  parameter int unsigned IFMAP_N        = cnn_pkg::IFMAP_N,
  parameter int unsigned COMPUTE_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef PE_TILE_LOADER_FILTER_REUSE_EN
  input  logic                         keep_filter,
`endif
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data,
  output logic [FILTER_N*DATA_W-1:0]   filter_in_flat,
  output logic [IFMAP_N*DATA_W-1:0]    ifmap_in_flat,
  output logic                         arr_rst,
  output logic                         arr_en,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned CmpW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  loader_state_e   state_q, state_d;
  logic [CmpW-1:0] cmp_cnt_q, cmp_cnt_d;
  logic            started_q, started_d;

  logic xfer, flt_wr, ifm_wr, flt_last, ifm_last;

  assign xfer   = s_valid & s_ready;
  assign flt_wr = xfer & (state_q == LOAD_FLT);
  assign ifm_wr = xfer & (state_q == LOAD_IFM);

  elem_collector #(
    .N      (FILTER_N),
    .DATA_W (DATA_W)
  ) u_flt (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (flt_wr),
    .data_i  (s_data),
    .flat_o  (filter_in_flat),
    .last_o  (flt_last)
  );

  elem_collector #(
    .N      (IFMAP_N),
    .DATA_W (DATA_W)
  ) u_ifm (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (ifm_wr),
    .data_i  (s_data),
    .flat_o  (ifmap_in_flat),
    .last_o  (ifm_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD_FLT;
      cmp_cnt_q <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmp_cnt_q <= cmp_cnt_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmp_cnt_d = cmp_cnt_q;
    started_d = started_q | xfer;
    unique case (state_q)
      LOAD_FLT: if (flt_wr && flt_last) state_d = LOAD_IFM;
      LOAD_IFM: if (ifm_wr && ifm_last) state_d = ARR_RST;
      ARR_RST: begin
        state_d   = COMPUTE;
        cmp_cnt_d = '0;
      end
      COMPUTE: begin
        if (cmp_cnt_q == CmpW'(COMPUTE_CYCLES - 1)) begin
          state_d   = DONE;
          cmp_cnt_d = '0;
        end else begin
          cmp_cnt_d = cmp_cnt_q + CmpW'(1);
        end
      end
      DONE: begin
        started_d = 1'b0;
        state_d   = LOAD_FLT;
`ifdef PE_TILE_LOADER_FILTER_REUSE_EN
        // DONE is only reachable after a full filter load, so the kept filter is always valid.
        if (keep_filter) state_d = LOAD_IFM;
`endif
      end
      default: state_d = LOAD_FLT;
    endcase
  end

  // arr_rst follows rst combinationally so the array is held in reset with the loader.
  always_comb begin
    s_ready = 1'b0;
    arr_rst = rst;
    arr_en  = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        LOAD_FLT, LOAD_IFM: begin
          s_ready = 1'b1;
          busy    = started_q;
        end
        ARR_RST: begin
          arr_rst = 1'b1;
          busy    = 1'b1;
        end
        COMPUTE: begin
          arr_en = 1'b1;
          busy   = 1'b1;
        end
        DONE: begin
          done = 1'b1;
          busy = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
